// File: rtl/mem_bridge.sv
// Load/store access unit between the multicycle CPU datapath and an Avalon-MM master port.
// Aligns byteenable/writedata, holds the transfer across waitrequest, formats load data.
module mem_bridge #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        stall_o,
  output logic [31:0] avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  input  logic        avm_waitrequest_i,
  output logic [31:0] avm_writedata_o,
  output logic [3:0]  avm_byteenable_o,
  input  logic [31:0] avm_readdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [1:0]  r_lane;
  logic        r_err;
  logic [31:0] r_wdog;
  logic [31:0] r_rdata;
  logic [31:0] r_avm_address;
  logic [31:0] r_avm_writedata;
  logic [3:0]  r_avm_byteenable;

  logic        w_illegal;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_illegal = (size_i == 2'b11)
                   | ((size_i == SZ_HALF) & addr_i[0])
                   | ((size_i == SZ_WORD) & (addr_i[1:0] != 2'b00));

  // Watchdog fires on the TIMEOUT-th stalled bus cycle, so the bus strobe is high exactly TIMEOUT cycles.
  assign w_timeout = (TIMEOUT != 0) && avm_waitrequest_i && (r_wdog == TIMEOUT - 1);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = avm_readdata_i[7:0];
    case (r_lane)
      2'd1:    w_byte = avm_readdata_i[15:8];
      2'd2:    w_byte = avm_readdata_i[23:16];
      2'd3:    w_byte = avm_readdata_i[31:24];
      default: ;
    endcase
    w_half = r_lane[1] ? avm_readdata_i[31:16] : avm_readdata_i[15:0];
    case (r_size)
      SZ_BYTE: w_load = {{24{r_sign & w_byte[7]}}, w_byte};
      SZ_HALF: w_load = {{16{r_sign & w_half[15]}}, w_half};
      default: w_load = avm_readdata_i;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_i) w_state_nxt = w_illegal ? S_FIN : S_BUS;
      S_BUS:   if (!avm_waitrequest_i || w_timeout) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state          <= S_IDLE;
      r_we             <= 1'b0;
      r_size           <= 2'b00;
      r_sign           <= 1'b0;
      r_lane           <= 2'b00;
      r_err            <= 1'b0;
      r_wdog           <= '0;
      r_rdata          <= '0;
      r_avm_address    <= '0;
      r_avm_writedata  <= '0;
      r_avm_byteenable <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          r_wdog <= '0;
          if (req_i) begin
            r_we   <= we_i;
            r_size <= size_i;
            r_sign <= sign_i;
            r_lane <= addr_i[1:0];
            r_err  <= w_illegal;
            if (!w_illegal) begin
              r_avm_address    <= {addr_i[31:2], 2'b00};
              r_avm_writedata  <= w_wdata;
              r_avm_byteenable <= w_be;
            end
          end
        end
        S_BUS: begin
          if (avm_waitrequest_i) begin
            r_wdog <= r_wdog + 32'd1;
            if (w_timeout) r_err <= 1'b1;
          end else if (!r_we) begin
            r_rdata <= w_load;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata_o          = r_rdata;
  assign done_o           = (r_state == S_FIN);
  assign err_o            = (r_state == S_FIN) & r_err;
  assign stall_o          = ((r_state == S_IDLE) & req_i) | (r_state == S_BUS);
  assign avm_read_o       = (r_state == S_BUS) & !r_we;
  assign avm_write_o      = (r_state == S_BUS) & r_we;
  assign avm_address_o    = r_avm_address;
  assign avm_writedata_o  = r_avm_writedata;
  assign avm_byteenable_o = r_avm_byteenable;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge: aligned/unaligned loads, stalled store,
// illegal requests, watchdog abort and reset during a stalled bus cycle.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        sign_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        err_o;
  logic        stall_o;
  logic [31:0] avm_address_o;
  logic        avm_read_o;
  logic        avm_write_o;
  logic        avm_waitrequest_i = 1'b0;
  logic [31:0] avm_writedata_o;
  logic [3:0]  avm_byteenable_o;
  logic [31:0] avm_readdata_i = '0;

  int n_checks = 0;
  int n_pass   = 0;

  mem_bridge #(.TIMEOUT(8)) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .req_i             (req_i),
    .we_i              (we_i),
    .size_i            (size_i),
    .sign_i            (sign_i),
    .addr_i            (addr_i),
    .wdata_i           (wdata_i),
    .rdata_o           (rdata_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .stall_o           (stall_o),
    .avm_address_o     (avm_address_o),
    .avm_read_o        (avm_read_o),
    .avm_write_o       (avm_write_o),
    .avm_waitrequest_i (avm_waitrequest_i),
    .avm_writedata_o   (avm_writedata_o),
    .avm_byteenable_o  (avm_byteenable_o),
    .avm_readdata_i    (avm_readdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after the following falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_i   = 1'b1;
    we_i    = we;
    size_i  = sz;
    sign_i  = sg;
    addr_i  = a;
    wdata_i = wd;
    #1;
  endtask

  // Zero-wait load: bus cycle at T+1, done and formatted data at T+2.
  task automatic load(input string tag, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] rd,
                      input logic [3:0] be, input logic [31:0] exp);
    avm_waitrequest_i = 1'b0;
    avm_readdata_i    = rd;
    drive(1'b0, sz, sg, a, 32'h0);
    check({tag, " stall_req"}, {31'd0, stall_o}, 32'd1);
    step();
    req_i = 1'b0;
    #1;
    check({tag, " read"}, {30'd0, avm_read_o, avm_write_o}, 32'd2);
    check({tag, " addr"}, avm_address_o, {a[31:2], 2'b00});
    check({tag, " be"}, {28'd0, avm_byteenable_o}, {28'd0, be});
    step();
    check({tag, " done"}, {29'd0, done_o, err_o, stall_o}, 32'b100);
    check({tag, " rdata"}, rdata_o, exp);
    step();
    check({tag, " idle"}, {30'd0, done_o, avm_read_o}, 32'd0);
  endtask

  // Illegal request: done+err at T+1, no bus strobe, rdata untouched.
  task automatic illegal(input string tag, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] rd_before);
    drive(we, sz, 1'b0, a, 32'h1234_5678);
    step();
    req_i = 1'b0;
    #1;
    check({tag, " done_err"}, {30'd0, done_o, err_o}, 32'd3);
    check({tag, " no_bus"}, {30'd0, avm_read_o, avm_write_o}, 32'd0);
    check({tag, " rdata_kept"}, rdata_o, rd_before);
    step();
    check({tag, " back_idle"}, {29'd0, done_o, avm_read_o, avm_write_o}, 32'd0);
  endtask

  initial begin
    int wcnt;
    logic seen;

    step();
    step();
    check("reset outs", {25'd0, done_o, err_o, stall_o, avm_read_o, avm_write_o, 2'd0}, 32'd0);
    check("reset rdata", rdata_o, 32'd0);
    check("reset addr", avm_address_o, 32'd0);
    check("reset be", {28'd0, avm_byteenable_o}, 32'd0);
    reset_i = 1'b0;
    step();

    load("LW",  2'b10, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    load("LB",  2'b00, 1'b1, 32'h0000_1003, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
    load("LBU", 2'b00, 1'b0, 32'h0000_1003, 32'h80FF_1234, 4'b1000, 32'h0000_0080);
    load("LHU", 2'b01, 1'b0, 32'h0000_1002, 32'h80FF_1234, 4'b1100, 32'h0000_80FF);
    load("LH",  2'b01, 1'b1, 32'h0000_1002, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF);
    load("LB0", 2'b00, 1'b1, 32'h0000_1000, 32'h80FF_1234, 4'b0001, 32'h0000_0034);
    load("LB1", 2'b00, 1'b1, 32'h0000_1005, 32'h80FF_1234, 4'b0010, 32'h0000_0012);

    // SH with waitrequest high for 3 bus cycles: write held 4 cycles.
    avm_waitrequest_i = 1'b1;
    drive(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    step();
    req_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) avm_waitrequest_i = 1'b0;
      #1;
      check($sformatf("SH c%0d strobe", i), {29'd0, avm_read_o, avm_write_o, stall_o}, 32'b011);
      check($sformatf("SH c%0d addr", i), avm_address_o, 32'h0000_2000);
      check($sformatf("SH c%0d be", i), {28'd0, avm_byteenable_o}, 32'hC);
      check($sformatf("SH c%0d wdata", i), avm_writedata_o, 32'hBEEF_BEEF);
      check($sformatf("SH c%0d no_done", i), {31'd0, done_o}, 32'd0);
      step();
    end
    check("SH done", {28'd0, done_o, err_o, stall_o, avm_write_o}, 32'b1000);
    check("SH rdata_kept", rdata_o, 32'h0000_0012);
    step();

    // SB replicates the byte across lanes.
    avm_waitrequest_i = 1'b0;
    drive(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'hAABB_CC5A);
    step();
    req_i = 1'b0;
    #1;
    check("SB be", {28'd0, avm_byteenable_o}, 32'h2);
    check("SB wdata", avm_writedata_o, 32'h5A5A_5A5A);
    step();
    check("SB done", {30'd0, done_o, err_o}, 32'd2);
    step();

    illegal("ILL LW", 1'b0, 2'b10, 32'h0000_1002, 32'h0000_0012);
    illegal("ILL SZ", 1'b0, 2'b11, 32'h0000_1000, 32'h0000_0012);
    illegal("ILL SH", 1'b1, 2'b01, 32'h0000_2001, 32'h0000_0012);

    // SW with waitrequest stuck high: watchdog aborts after 8 write cycles.
    avm_waitrequest_i = 1'b1;
    drive(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h0102_0304);
    wcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      req_i = 1'b0;
      #1;
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (avm_write_o) wcnt++;
    end
    check("TO done_seen", {31'd0, seen}, 32'd1);
    check("TO write_cycles", wcnt, 32'd8);
    check("TO err", {29'd0, err_o, avm_write_o, stall_o}, 32'b100);
    step();
    check("TO idle", {29'd0, done_o, err_o, avm_write_o}, 32'd0);

    // Reset during a stalled load drops the transaction.
    drive(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
    step();
    req_i = 1'b0;
    #1;
    check("RST pre_read", {31'd0, avm_read_o}, 32'd1);
    reset_i = 1'b1;
    step();
    check("RST outs", {27'd0, avm_read_o, avm_write_o, stall_o, done_o, err_o}, 32'd0);
    check("RST rdata", rdata_o, 32'd0);
    check("RST addr", avm_address_o, 32'd0);
    reset_i = 1'b0;
    avm_waitrequest_i = 1'b0;
    step();
    load("LW after rst", 2'b10, 1'b0, 32'h0000_6000, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
